// File: rtl/lru_stack_multiset_pkg.sv
// Shared types and helpers for the multi-set LRU recency-stack tracker.
package lru_pkg;

  typedef enum logic [1:0] {
    LRU_NOP,
    LRU_TOUCH,
    LRU_INVAL
  } lru_op_e;

  // Index width that never collapses to zero bits, so a single set still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lru_stack_next.sv
// Combinational next-state of one recency stack: touch promotes a way to MRU, inval demotes it to LRU.
module lru_stack_next
  import lru_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = 2
) (
  input  logic [NUM_WAYS*WAY_W-1:0] i_cur,
  input  lru_op_e                   i_op,
  input  logic [WAY_W-1:0]          i_way,
  output logic [NUM_WAYS*WAY_W-1:0] o_next
);

  logic [WAY_W-1:0] w_cur [NUM_WAYS];
  logic [WAY_W-1:0] w_nxt [NUM_WAYS];
  logic [WAY_W-1:0] w_pos;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_pack
    assign w_cur[g] = i_cur[g*WAY_W +: WAY_W];
    assign o_next[g*WAY_W +: WAY_W] = w_nxt[g];
  end

  // The stack is a permutation, so exactly one position matches the way.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (w_cur[i] == i_way) w_pos = WAY_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) w_nxt[i] = w_cur[i];
    case (i_op)
      LRU_TOUCH: begin
        w_nxt[0] = i_way;
        for (int i = 1; i < NUM_WAYS; i++) begin
          if (WAY_W'(i) <= w_pos) w_nxt[i] = w_cur[i-1];
        end
      end
      LRU_INVAL: begin
        for (int i = 0; i < NUM_WAYS - 1; i++) begin
          if (WAY_W'(i) >= w_pos) w_nxt[i] = w_cur[i+1];
        end
        w_nxt[NUM_WAYS-1] = i_way;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lru_stack_multiset.sv
// True-LRU tracker: one recency stack per set, touch/inval update ports and a registered LRU/MRU read port.
module lru_stack_multiset
  import lru_pkg::*;
#(
  parameter int  NUM_WAYS = 4,
  parameter int  NUM_SETS = 8,
  localparam int WAY_W    = clog2_min1(NUM_WAYS),
  localparam int SET_W    = clog2_min1(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             inval,
  input  logic [SET_W-1:0] inval_set,
  input  logic [WAY_W-1:0] inval_way,
  input  logic [SET_W-1:0] rd_set,
  output logic [WAY_W-1:0] lru_way,
  output logic [WAY_W-1:0] mru_way
);

  localparam int STK_W = NUM_WAYS * WAY_W;

  logic [STK_W-1:0] r_stack [NUM_SETS];
  logic [WAY_W-1:0] r_lru;
  logic [WAY_W-1:0] r_mru;

  logic [STK_W-1:0] w_rst_stack;
  logic [STK_W-1:0] w_touch_next;
  logic [STK_W-1:0] w_inval_next;
  lru_op_e          w_touch_op;
  lru_op_e          w_inval_op;
  logic             w_inval_we;

  // Reset order puts way 0 at LRU and way NUM_WAYS-1 at MRU.
  always_comb begin
    w_rst_stack = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      w_rst_stack[i*WAY_W +: WAY_W] = WAY_W'(NUM_WAYS - 1 - i);
    end
  end

  assign w_touch_op = touch ? LRU_TOUCH : LRU_NOP;
  assign w_inval_op = inval ? LRU_INVAL : LRU_NOP;

  // A hit on the same set wins over an invalidate.
  assign w_inval_we = inval && !(touch && (touch_set == inval_set));

  lru_stack_next #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_touch_next (
    .i_cur  (r_stack[touch_set]),
    .i_op   (w_touch_op),
    .i_way  (touch_way),
    .o_next (w_touch_next)
  );

  lru_stack_next #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_inval_next (
    .i_cur  (r_stack[inval_set]),
    .i_op   (w_inval_op),
    .i_way  (inval_way),
    .o_next (w_inval_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) r_stack[s] <= w_rst_stack;
      r_lru <= '0;
      r_mru <= WAY_W'(NUM_WAYS - 1);
    end else begin
      if (touch)      r_stack[touch_set] <= w_touch_next;
      if (w_inval_we) r_stack[inval_set] <= w_inval_next;
      // Read port samples the stack as it stood before this edge's update.
      r_lru <= r_stack[rd_set][(NUM_WAYS-1)*WAY_W +: WAY_W];
      r_mru <= r_stack[rd_set][0 +: WAY_W];
    end
  end

  assign lru_way = r_lru;
  assign mru_way = r_mru;

endmodule

// File: tb/tb_lru_stack_multiset.sv
// Bench for lru_stack_multiset: directed scenarios plus a randomized run against a queue-based recency model.
module tb_lru_stack_multiset;

  localparam int NW = 4;
  localparam int NS = 8;
  localparam int WW = 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          touch = 1'b0;
  logic [SW-1:0] touch_set = '0;
  logic [WW-1:0] touch_way = '0;
  logic          inval = 1'b0;
  logic [SW-1:0] inval_set = '0;
  logic [WW-1:0] inval_way = '0;
  logic [SW-1:0] rd_set = '0;
  logic [WW-1:0] lru_way;
  logic [WW-1:0] mru_way;

  int vectors = 0;
  int miscompares = 0;

  // Model: per set a queue of ways ordered MRU first.
  int q [NS][$];
  int exp_lru;
  int exp_mru;

  lru_stack_multiset #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .touch     (touch),
    .touch_set (touch_set),
    .touch_way (touch_way),
    .inval     (inval),
    .inval_set (inval_set),
    .inval_way (inval_way),
    .rd_set    (rd_set),
    .lru_way   (lru_way),
    .mru_way   (mru_way)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      q[s].delete();
      for (int i = 0; i < NW; i++) q[s].push_back(NW - 1 - i);
    end
  endfunction

  function automatic void model_remove(input int s, input int w);
    for (int i = 0; i < q[s].size(); i++) begin
      if (q[s][i] == w) begin
        q[s].delete(i);
        break;
      end
    end
  endfunction

  // One clock: apply inputs, predict the read port and advance the model, then sample #1 after the edge.
  task automatic do_cycle(input bit r, input bit t, input int ts, input int tw,
                          input bit v, input int vs, input int vw, input int rs);
    rst = r; touch = t; touch_set = SW'(ts); touch_way = WW'(tw);
    inval = v; inval_set = SW'(vs); inval_way = WW'(vw); rd_set = SW'(rs);
    if (r) begin
      exp_lru = 0;
      exp_mru = NW - 1;
      model_reset();
    end else begin
      exp_lru = q[rs][NW-1];
      exp_mru = q[rs][0];
      if (t) begin
        model_remove(ts, tw);
        q[ts].push_front(tw);
      end
      if (v && !(t && ts == vs)) begin
        model_remove(vs, vw);
        q[vs].push_back(vw);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; touch = 1'b0; inval = 1'b0;
  endtask

  task automatic read_set(input int s);
    do_cycle(0, 0, 0, 0, 0, 0, 0, s);
  endtask

  task automatic test_reset();
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < NS; k++) begin
      read_set(k);
      vectors++;
      if (lru_way !== WW'(0) || mru_way !== WW'(NW - 1)) begin
        miscompares++;
        $display("FAIL reset_set%0d: lru=%0d mru=%0d, required lru=0 mru=%0d", k, lru_way, mru_way, NW - 1);
      end
    end
  endtask

  task automatic test_touch();
    for (int w = 0; w < NW; w++) do_cycle(0, 1, 2, w, 0, 0, 0, 0);
    read_set(2);
    vectors++;
    if (lru_way !== 2'd0 || mru_way !== 2'd3) begin
      miscompares++;
      $display("FAIL touch_order: lru=%0d mru=%0d, required lru=0 mru=3", lru_way, mru_way);
    end
    do_cycle(0, 1, 2, 0, 0, 0, 0, 0);
    read_set(2);
    vectors++;
    if (lru_way !== 2'd1 || mru_way !== 2'd0) begin
      miscompares++;
      $display("FAIL touch_retouch0: lru=%0d mru=%0d, required lru=1 mru=0", lru_way, mru_way);
    end
    do_cycle(0, 1, 2, 0, 0, 0, 0, 0);
    read_set(2);
    vectors++;
    if (lru_way !== 2'd1 || mru_way !== 2'd0) begin
      miscompares++;
      $display("FAIL touch_idempotent: lru=%0d mru=%0d, required lru=1 mru=0", lru_way, mru_way);
    end
    read_set(6);
    vectors++;
    if (lru_way !== 2'd0 || mru_way !== 2'd3) begin
      miscompares++;
      $display("FAIL touch_other_set: lru=%0d mru=%0d, required lru=0 mru=3", lru_way, mru_way);
    end
  endtask

  task automatic test_inval();
    for (int n = 0; n < 2; n++) begin
      do_cycle(0, 0, 0, 0, 1, 5, 3, 0);
      read_set(5);
      vectors++;
      if (lru_way !== 2'd3 || mru_way !== 2'd2) begin
        miscompares++;
        $display("FAIL inval_pass%0d: lru=%0d mru=%0d, required lru=3 mru=2", n, lru_way, mru_way);
      end
    end
    do_cycle(0, 0, 0, 0, 1, 7, 1, 0);
    read_set(7);
    vectors++;
    if (lru_way !== 2'd1 || mru_way !== 2'd3) begin
      miscompares++;
      $display("FAIL inval_mid: lru=%0d mru=%0d, required lru=1 mru=3", lru_way, mru_way);
    end
  endtask

  task automatic test_conflict();
    do_cycle(0, 1, 1, 0, 1, 1, 2, 0);
    read_set(1);
    vectors++;
    if (lru_way !== 2'd1 || mru_way !== 2'd0) begin
      miscompares++;
      $display("FAIL conflict_same_set: lru=%0d mru=%0d, required lru=1 mru=0", lru_way, mru_way);
    end
    do_cycle(0, 1, 1, 0, 1, 4, 2, 0);
    read_set(4);
    vectors++;
    if (lru_way !== 2'd2 || mru_way !== 2'd3) begin
      miscompares++;
      $display("FAIL conflict_diff_set: lru=%0d mru=%0d, required lru=2 mru=3", lru_way, mru_way);
    end
  endtask

  task automatic test_read_old();
    do_cycle(0, 1, 3, 0, 0, 0, 0, 3);
    vectors++;
    if (mru_way !== 2'd3) begin
      miscompares++;
      $display("FAIL read_old_same_cycle: mru=%0d, required 3", mru_way);
    end
    read_set(3);
    vectors++;
    if (mru_way !== 2'd0) begin
      miscompares++;
      $display("FAIL read_old_next_cycle: mru=%0d, required 0", mru_way);
    end
  endtask

  task automatic test_reset_mid();
    do_cycle(0, 1, 0, 1, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 6, 3, 0);
    do_cycle(1, 1, 0, 0, 1, 2, 3, 0);
    vectors++;
    if (lru_way !== 2'd0 || mru_way !== 2'd3) begin
      miscompares++;
      $display("FAIL reset_mid_out: lru=%0d mru=%0d, required lru=0 mru=3", lru_way, mru_way);
    end
    for (int k = 0; k < NS; k++) begin
      read_set(k);
      vectors++;
      if (lru_way !== 2'd0 || mru_way !== 2'd3) begin
        miscompares++;
        $display("FAIL reset_mid_set%0d: lru=%0d mru=%0d, required lru=0 mru=3", k, lru_way, mru_way);
      end
    end
  endtask

  task automatic test_random();
    int ts, tw, vs, vw, rs, got, seen;
    bit t, v;
    for (int c = 0; c < 400; c++) begin
      t  = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 2) == 0);
      ts = $urandom_range(0, NS - 1);
      vs = ($urandom_range(0, 3) == 0) ? ts : $urandom_range(0, NS - 1);
      tw = $urandom_range(0, NW - 1);
      vw = $urandom_range(0, NW - 1);
      rs = $urandom_range(0, NS - 1);
      do_cycle(0, t, ts, tw, v, vs, vw, rs);
      vectors++;
      if (lru_way !== WW'(exp_lru) || mru_way !== WW'(exp_mru)) begin
        miscompares++;
        $display("FAIL random_port c=%0d set=%0d: lru=%0d mru=%0d, required lru=%0d mru=%0d",
                 c, rs, lru_way, mru_way, exp_lru, exp_mru);
      end
      for (int s = 0; s < NS; s++) begin
        seen = 0;
        for (int i = 0; i < NW; i++) begin
          got = int'(dut.r_stack[s][i*WW +: WW]);
          seen = seen | (1 << got);
          vectors++;
          if (got != q[s][i]) begin
            miscompares++;
            $display("FAIL random_stack c=%0d set=%0d pos=%0d: got %0d, required %0d", c, s, i, got, q[s][i]);
          end
        end
        vectors++;
        if (seen != (1 << NW) - 1) begin
          miscompares++;
          $display("FAIL random_perm c=%0d set=%0d: way mask %0h, required %0h", c, s, seen, (1 << NW) - 1);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_touch();
    test_inval();
    test_conflict();
    test_read_old();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
